// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP stream detector: class indices, fmt/type codes
// and header/payload size arithmetic.
package tlp_pkg;

  localparam int NUM_TLP_CLASSES = 13;

  localparam int CLS_MRD32  = 0;
  localparam int CLS_MRD64  = 1;
  localparam int CLS_MRDLK  = 2;
  localparam int CLS_IORD   = 3;
  localparam int CLS_IOWR   = 4;
  localparam int CLS_CFGRD0 = 5;
  localparam int CLS_CFGWR0 = 6;
  localparam int CLS_CFGRD1 = 7;
  localparam int CLS_CFGWR1 = 8;
  localparam int CLS_CPL    = 9;
  localparam int CLS_CPLD   = 10;
  localparam int CLS_MWR32  = 11;
  localparam int CLS_MWR64  = 12;

  localparam logic [7:0] CODE_MRD32  = 8'h00;
  localparam logic [7:0] CODE_MRD64  = 8'h20;
  localparam logic [7:0] CODE_MRDLK  = 8'h01;
  localparam logic [7:0] CODE_IORD   = 8'h02;
  localparam logic [7:0] CODE_IOWR   = 8'h42;
  localparam logic [7:0] CODE_CFGRD0 = 8'h04;
  localparam logic [7:0] CODE_CFGWR0 = 8'h44;
  localparam logic [7:0] CODE_CFGRD1 = 8'h05;
  localparam logic [7:0] CODE_CFGWR1 = 8'h45;
  localparam logic [7:0] CODE_CPL    = 8'h0A;
  localparam logic [7:0] CODE_CPLD   = 8'h4A;
  localparam logic [7:0] CODE_MWR32  = 8'h40;
  localparam logic [7:0] CODE_MWR64  = 8'h60;

  typedef enum logic {ST_IDLE, ST_BODY} det_state_t;

  function automatic logic [2:0] tlp_hdr_dw(input logic [7:0] code);
    return code[5] ? 3'd4 : 3'd3;
  endfunction

  // Total DWs the header promises: header + payload (len 0 means 1024) + digest.
  function automatic logic [10:0] tlp_exp_dw(input logic [7:0] code, input logic [9:0] len,
                                             input logic td);
    logic [10:0] pay;
    pay = code[6] ? ((len == 10'd0) ? 11'd1024 : {1'b0, len}) : 11'd0;
    return {8'd0, tlp_hdr_dw(code)} + pay + {10'd0, td};
  endfunction

endpackage

// File: rtl/tlp_class_decode.sv
// Combinational fmt/type byte to one-hot class decoder; masked-off or unknown
// codes come out all-zero and flagged unsupported.
module tlp_class_decode
  import tlp_pkg::*;
#(
  parameter logic [NUM_TLP_CLASSES-1:0] TYPE_MASK = 13'h1FFF
) (
  input  logic [7:0]                 i_code,
  output logic [NUM_TLP_CLASSES-1:0] o_class,
  output logic                       o_unsup
);

  logic [NUM_TLP_CLASSES-1:0] w_raw;

  always_comb begin
    w_raw = '0;
    case (i_code)
      CODE_MRD32:  w_raw[CLS_MRD32]  = 1'b1;
      CODE_MRD64:  w_raw[CLS_MRD64]  = 1'b1;
      CODE_MRDLK:  w_raw[CLS_MRDLK]  = 1'b1;
      CODE_IORD:   w_raw[CLS_IORD]   = 1'b1;
      CODE_IOWR:   w_raw[CLS_IOWR]   = 1'b1;
      CODE_CFGRD0: w_raw[CLS_CFGRD0] = 1'b1;
      CODE_CFGWR0: w_raw[CLS_CFGWR0] = 1'b1;
      CODE_CFGRD1: w_raw[CLS_CFGRD1] = 1'b1;
      CODE_CFGWR1: w_raw[CLS_CFGWR1] = 1'b1;
      CODE_CPL:    w_raw[CLS_CPL]    = 1'b1;
      CODE_CPLD:   w_raw[CLS_CPLD]   = 1'b1;
      CODE_MWR32:  w_raw[CLS_MWR32]  = 1'b1;
      CODE_MWR64:  w_raw[CLS_MWR64]  = 1'b1;
      default:     w_raw = '0;
    endcase
  end

  assign o_class = w_raw & TYPE_MASK;
  assign o_unsup = ~|o_class;

endmodule

// File: rtl/tlp_stream_detector.sv
// Passive TLP stream monitor: one registered class/length/error report per TLP,
// plus saturating TLP and error counters.
module tlp_stream_detector
  import tlp_pkg::*;
#(
  parameter int                         CNT_W      = 16,
  parameter bit                         STRICT_LEN = 1'b1,
  parameter logic [NUM_TLP_CLASSES-1:0] TYPE_MASK  = 13'h1FFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [31:0]                in_data,
  output logic                       det_valid,
  output logic [NUM_TLP_CLASSES-1:0] det_type,
  output logic [9:0]                 det_len,
  output logic                       det_err_unsup,
  output logic                       det_err_len,
  output logic                       det_err_trunc,
  output logic [CNT_W-1:0]           tlp_count,
  output logic [CNT_W-1:0]           err_count
);

  det_state_t                 r_state, w_state_nx;
  logic [NUM_TLP_CLASSES-1:0] r_class, w_dec_class, w_rep_class;
  logic                       r_unsup, w_dec_unsup, w_rep_unsup;
  logic [9:0]                 r_len, w_rep_len;
  logic [10:0]                r_exp, w_new_exp;
  logic [10:0]                r_cnt, w_cnt_nx, w_cnt_inc;
  logic                       w_start, w_rep, w_rep_elen, w_rep_trunc;
  logic                       w_unused_bits;

  tlp_class_decode #(.TYPE_MASK(TYPE_MASK)) u_decode (
    .i_code  (in_data[31:24]),
    .o_class (w_dec_class),
    .o_unsup (w_dec_unsup)
  );

  assign w_new_exp     = tlp_exp_dw(in_data[31:24], in_data[9:0], in_data[15]);
  assign w_cnt_inc     = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_unused_bits = ^{in_data[23:16], in_data[14:10]};

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_start     = 1'b0;
    w_rep       = 1'b0;
    w_rep_class = r_class;
    w_rep_unsup = r_unsup;
    w_rep_len   = r_len;
    w_rep_elen  = 1'b0;
    w_rep_trunc = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (in_sop) begin
            w_start  = 1'b1;
            w_cnt_nx = 11'd1;
            if (in_eop) begin
              // Single-beat TLP reports its own freshly decoded header.
              w_rep       = 1'b1;
              w_rep_class = w_dec_class;
              w_rep_unsup = w_dec_unsup;
              w_rep_len   = in_data[9:0];
              w_rep_elen  = STRICT_LEN && (w_new_exp != 11'd1);
            end else begin
              w_state_nx = ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (in_sop) begin
            // Abort: report the previous TLP as truncated, start the new one.
            w_rep       = 1'b1;
            w_rep_trunc = 1'b1;
            w_start     = 1'b1;
            w_cnt_nx    = 11'd1;
            w_state_nx  = in_eop ? ST_IDLE : ST_BODY;
          end else begin
            w_cnt_nx = w_cnt_inc;
            if (in_eop) begin
              w_rep      = 1'b1;
              w_rep_elen = STRICT_LEN && (w_cnt_inc != r_exp);
              w_state_nx = ST_IDLE;
            end
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_class <= '0;
      r_unsup <= 1'b0;
      r_len   <= '0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_start) begin
        r_class <= w_dec_class;
        r_unsup <= w_dec_unsup;
        r_len   <= in_data[9:0];
        r_exp   <= w_new_exp;
      end
    end
  end

  // Report stage: fields hold between reports, counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_valid     <= 1'b0;
      det_type      <= '0;
      det_len       <= '0;
      det_err_unsup <= 1'b0;
      det_err_len   <= 1'b0;
      det_err_trunc <= 1'b0;
      tlp_count     <= '0;
      err_count     <= '0;
    end else begin
      det_valid <= w_rep;
      if (w_rep) begin
        det_type      <= w_rep_class;
        det_len       <= w_rep_len;
        det_err_unsup <= w_rep_unsup;
        det_err_len   <= w_rep_elen;
        det_err_trunc <= w_rep_trunc;
        if (tlp_count != {CNT_W{1'b1}}) tlp_count <= tlp_count + 1'b1;
        if ((w_rep_unsup || w_rep_elen || w_rep_trunc) && (err_count != {CNT_W{1'b1}}))
          err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/tlp_stream_detector.md
Name: tlp_stream_detector

Overview:
Sequential successor to the combinational fmt/type decoder. Monitors a 32-bit-per-beat TLP stream (one DW per beat, sop/eop framed). For each TLP it decodes the header fmt/type byte to a one-hot class, extracts length, checks beat count against the header-implied size, and reports one registered result per TLP. Also keeps saturating statistics counters. Passive sink; no backpressure.

Parameters:
CNT_W, 16, width of the statistics counters tlp_count and err_count.
STRICT_LEN, 1, 1 = length mismatch flagged as error; 0 = length check disabled (det_err_len forced 0).
TYPE_MASK, 13'h1FFF, per-class enable; a decoded class with mask bit 0 is reported as unsupported.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  beat qualifier.
in_sop  input  1  first DW of TLP, valid only with in_valid.
in_eop  input  1  last DW of TLP, valid only with in_valid.
in_data  input  32  DW; on the sop beat [31:24]=fmt/type byte, [15]=TD, [9:0]=length.
det_valid  output  1  one-cycle pulse, result fields valid.
det_type  output  13  one-hot class, all-zero if unsupported.
det_len  output  10  raw length field of the reported TLP.
det_err_unsup  output  1  fmt/type not in table or masked off.
det_err_len  output  1  beat count differs from expected.
det_err_trunc  output  1  TLP aborted by a new sop before eop.
tlp_count  output  CNT_W  saturating count of reported TLPs.
err_count  output  CNT_W  saturating count of reports with any error flag.

Behaviour:
- Reset (async, rst=1): state IDLE; det_valid=0, det_type=0, det_len=0, all err flags 0, tlp_count=0, err_count=0. Reset mid-TLP discards it, no report.
- Class table (index: code): 0 MRd32 00, 1 MRd64 20, 2 MRdLk 01, 3 IORd 02, 4 IOWr 42, 5 CfgRd0 04, 6 CfgWr0 44, 7 CfgRd1 05, 8 CfgWr1 45, 9 Cpl 0A, 10 CplD 4A, 11 MWr32 40, 12 MWr64 60. Any other code -> unsupported.
- Expected DW count (11-bit): hdr = fmt[5]?4:3; plus payload = fmt[6] ? (len==0 ? 1024 : len) : 0; plus TD ? 1 : 0. Max 1029.
- States: IDLE, BODY.
- IDLE: beats without sop ignored. sop beat: latch class, len, expected; beat count := 1. If eop on same beat -> report immediately (count 1, always length error when STRICT_LEN). Else -> BODY.
- BODY: each valid beat increments count (saturates at 2047). eop -> report, -> IDLE. sop without eop in BODY -> report previous with det_err_trunc=1 (len error not evaluated), then treat beat as new sop (same cycle, stays/returns per eop).
- Report: registered, det_valid high the cycle after the eop/abort beat, exactly one cycle; det_* fields hold until next report.
- det_err_len = STRICT_LEN && count != expected. Unsupported TLPs still length-checked using fmt bits of the byte.
- tlp_count increments per report; err_count increments when any err flag set; both saturate at all-ones, no wrap.
- in_valid=0 beats never advance state or count; sop/eop ignored when in_valid=0.

Decomposition:
- Package tlp_pkg: NUM_TLP_CLASSES=13, class index localparams, 8-bit fmt/type code constants, header-size function.
- Sub-module tlp_class_decode: combinational fmt/type byte -> 13-bit one-hot plus unsupported flag, masked by TYPE_MASK.

Test Plan:
- MRd32 sop data 0x0000_0001, 3 beats, eop on beat 3 -> det_valid next cycle, det_type=13'h0001, det_len=1, no errors, tlp_count=1.
- MWr64 code 0x60 len=2, 6 beats -> det_type bit 12, no error; repeat with 5 beats -> det_err_len=1, err_count=1.
- CplD 0x4A len=0 (1024 DW) with TD=1, 1028 beats -> no error; STRICT_LEN=0 with 10 beats -> det_err_len=0.
- Code 0x7F, 3 beats -> det_type=0, det_err_unsup=1; TYPE_MASK bit 11 cleared, MWr32 -> unsupported.
- sop at beat 2 of an MRd32 -> first report det_err_trunc=1, second TLP reported normally after its eop.
- rst asserted mid-BODY -> all outputs 0 immediately, no det_valid; counters driven to saturation by forcing CNT_W=4, 17 TLPs -> tlp_count=15.
